// File: rtl/aoi211_exhaustive_checker.sv
`default_nettype none
// ============================================================================
// Module  : aoi211_exhaustive_checker
// Brief   : Drives all 16 input patterns into one AOI211 cell under test and
//           checks its ZN against ~((A1&A2)|B|C), reporting pass/fail, a
//           saturating mismatch count and the first failing pattern.
// Revision: 1.0 - initial release
// ============================================================================
module aoi211_exhaustive_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1,
  parameter int ERR_W         = 8
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             start,
  input  logic             abort,
  input  logic             zn_in,
  output logic             cut_a1,
  output logic             cut_a2,
  output logic             cut_b,
  output logic             cut_c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_idx,
  output logic             fail_valid
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_SAMPLE = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [3:0]       c_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0]       c_LOOPS       = 8'(LOOPS);
  localparam logic [ERR_W-1:0] c_ERR_MAX     = '1;

  state_t     r_state;
  logic [3:0] r_idx;
  logic [7:0] r_loop;
  logic [3:0] r_settle;

  logic       w_golden;
  logic       w_mismatch;
  logic [3:0] w_idx_next;
  logic [7:0] w_loop_next;
  logic       w_last_pattern;

  // idx bit order is {A1,A2,B,C}
  assign w_golden       = ~((r_idx[3] & r_idx[2]) | r_idx[1] | r_idx[0]);
  assign w_mismatch     = (zn_in != w_golden);
  assign w_idx_next     = r_idx + 4'd1;
  assign w_loop_next    = r_loop + 8'd1;
  assign w_last_pattern = (r_idx == 4'hF) && (w_loop_next == c_LOOPS);

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_state    <= S_IDLE;
      r_idx      <= 4'd0;
      r_loop     <= 8'd0;
      r_settle   <= 4'd0;
      cut_a1     <= 1'b0;
      cut_a2     <= 1'b0;
      cut_b      <= 1'b0;
      cut_c      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_idx   <= 4'd0;
      fail_valid <= 1'b0;
    end else if (abort && (r_state != S_IDLE)) begin
      // Partial err_count/fail_* are kept for post-mortem; the pending sample is dropped.
      r_state <= S_IDLE;
      busy    <= 1'b0;
      {cut_a1, cut_a2, cut_b, cut_c} <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            err_count  <= '0;
            fail_idx   <= 4'd0;
            fail_valid <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            r_idx      <= 4'd0;
            r_loop     <= 8'd0;
            r_settle   <= 4'd0;
            {cut_a1, cut_a2, cut_b, cut_c} <= 4'd0;
            r_state    <= S_HOLD;
          end
        end

        S_HOLD: begin
          if (r_settle == c_SETTLE_LAST) begin
            r_state <= S_SAMPLE;
          end else begin
            r_settle <= r_settle + 4'd1;
          end
        end

        S_SAMPLE: begin
          if (w_mismatch) begin
            if (err_count != c_ERR_MAX) begin
              err_count <= err_count + 1'b1;
            end
            if (!fail_valid) begin
              fail_idx   <= r_idx;
              fail_valid <= 1'b1;
            end
          end
          r_idx    <= w_idx_next;
          r_settle <= 4'd0;
          {cut_a1, cut_a2, cut_b, cut_c} <= w_idx_next;
          if (r_idx == 4'hF) begin
            r_loop <= w_loop_next;
          end
          r_state <= w_last_pattern ? S_FINISH : S_HOLD;
        end

        S_FINISH: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          pass    <= (err_count == '0);
          {cut_a1, cut_a2, cut_b, cut_c} <= 4'd0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aoi211_exhaustive_checker.sv
`default_nettype none
// ============================================================================
// Module  : tb_aoi211_exhaustive_checker
// Brief   : Directed-vector bench; three checker instances share start/abort/RN
//           and each drives its own behavioural CUT model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_aoi211_exhaustive_checker;

  logic CLK = 1'b0;
  logic RN  = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic tie0_mode = 1'b0;

  always #5 CLK = ~CLK;

  // Instance 1: defaults, CUT either correct or ZN stuck at 0
  logic       a1_1, a2_1, b_1, c_1, zn_1, busy_1, done_1, pass_1, fv_1;
  logic [7:0] err_1;
  logic [3:0] fidx_1;
  assign zn_1 = tie0_mode ? 1'b0 : ~((a1_1 & a2_1) | b_1 | c_1);

  aoi211_exhaustive_checker u_dut (
    .CLK(CLK), .RN(RN), .start(start), .abort(abort), .zn_in(zn_1),
    .cut_a1(a1_1), .cut_a2(a2_1), .cut_b(b_1), .cut_c(c_1),
    .busy(busy_1), .done(done_1), .pass(pass_1), .err_count(err_1),
    .fail_idx(fidx_1), .fail_valid(fv_1)
  );

  // Instance 2: LOOPS=2, CUT ignores B
  logic       a1_2, a2_2, b_2, c_2, zn_2, busy_2, done_2, pass_2, fv_2;
  logic [7:0] err_2;
  logic [3:0] fidx_2;
  assign zn_2 = ~((a1_2 & a2_2) | c_2);

  aoi211_exhaustive_checker #(.SETTLE_CYCLES(2), .LOOPS(2), .ERR_W(8)) u_dut_l2 (
    .CLK(CLK), .RN(RN), .start(start), .abort(abort), .zn_in(zn_2),
    .cut_a1(a1_2), .cut_a2(a2_2), .cut_b(b_2), .cut_c(c_2),
    .busy(busy_2), .done(done_2), .pass(pass_2), .err_count(err_2),
    .fail_idx(fidx_2), .fail_valid(fv_2)
  );

  // Instance 3: ERR_W=2, CUT output inverted on every pattern
  logic       a1_3, a2_3, b_3, c_3, zn_3, busy_3, done_3, pass_3, fv_3;
  logic [1:0] err_3;
  logic [3:0] fidx_3;
  assign zn_3 = (a1_3 & a2_3) | b_3 | c_3;

  aoi211_exhaustive_checker #(.SETTLE_CYCLES(2), .LOOPS(1), .ERR_W(2)) u_dut_e2 (
    .CLK(CLK), .RN(RN), .start(start), .abort(abort), .zn_in(zn_3),
    .cut_a1(a1_3), .cut_a2(a2_3), .cut_b(b_3), .cut_c(c_3),
    .busy(busy_3), .done(done_3), .pass(pass_3), .err_count(err_3),
    .fail_idx(fidx_3), .fail_valid(fv_3)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Leaves time at #1 after the start-accept edge
  task automatic pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done1(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (done_1) break;
      tick();
    end
    chk("done1_timeout", {31'd0, done_1}, 32'd1);
  endtask

  initial begin
    // ---------------- reset state ----------------
    #2;
    chk("rst_busy", {31'd0, busy_1}, 32'd0);
    chk("rst_cut",  {28'd0, a1_1, a2_1, b_1, c_1}, 32'd0);
    chk("rst_err",  {24'd0, err_1}, 32'd0);
    chk("rst_done_pass_fv", {29'd0, done_1, pass_1, fv_1}, 32'd0);
    tick();
    RN = 1'b1;
    tick();

    // ---------------- correct CUT, defaults ----------------
    tie0_mode = 1'b0;
    pulse_start();
    chk("run1_busy_t0", {31'd0, busy_1}, 32'd1);
    for (int t = 1; t <= 48; t++) begin
      tick();
      if (t % 3 == 1)
        chk($sformatf("run1_cut_t%0d", t), {28'd0, a1_1, a2_1, b_1, c_1}, 32'(t / 3));
    end
    chk("run1_busy_t48", {30'd0, busy_1, done_1}, 32'b10);
    tick();
    chk("run1_done_t49", {30'd0, busy_1, done_1}, 32'b01);
    chk("run1_pass",     {31'd0, pass_1}, 32'd1);
    chk("run1_err",      {24'd0, err_1}, 32'd0);
    chk("run1_fv",       {31'd0, fv_1}, 32'd0);
    chk("run1_cut_idle", {28'd0, a1_1, a2_1, b_1, c_1}, 32'd0);
    // ERR_W=2 instance finished at the same time with all 16 patterns wrong
    chk("e2_err_sat", {30'd0, err_3}, 32'd3);
    chk("e2_pass",    {31'd0, pass_3}, 32'd0);
    chk("e2_fidx",    {28'd0, fidx_3}, 32'd0);
    for (int t = 50; t <= 96; t++) tick();
    chk("l2_busy_t96", {30'd0, busy_2, done_2}, 32'b10);
    tick();
    chk("l2_done_t97", {30'd0, busy_2, done_2}, 32'b01);
    chk("l2_err",   {24'd0, err_2}, 32'd6);
    chk("l2_fidx",  {28'd0, fidx_2}, 32'h2);
    chk("l2_fv_pass", {30'd0, fv_2, pass_2}, 32'b10);
    chk("e2_err_stays", {30'd0, err_3}, 32'd3);

    // ---------------- ZN tied 0 ----------------
    tie0_mode = 1'b1;
    pulse_start();
    chk("tie0_done_drop", {31'd0, done_1}, 32'd0);
    wait_done1(60);
    chk("tie0_err",  {24'd0, err_1}, 32'd3);
    chk("tie0_pass", {31'd0, pass_1}, 32'd0);
    chk("tie0_fidx", {28'd0, fidx_1}, 32'h0);
    chk("tie0_fv",   {31'd0, fv_1}, 32'd1);

    // ---------------- abort at idx 5 ----------------
    pulse_start();
    for (int t = 1; t <= 15; t++) tick();
    chk("abort_cut5", {28'd0, a1_1, a2_1, b_1, c_1}, 32'd5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy_done", {30'd0, busy_1, done_1}, 32'b00);
    chk("abort_cut0", {28'd0, a1_1, a2_1, b_1, c_1}, 32'd0);
    chk("abort_err_partial", {24'd0, err_1}, 32'd2);
    chk("abort_fv_fidx", {27'd0, fv_1, fidx_1}, 32'h10);
    tick();
    chk("abort_stay_idle", {31'd0, busy_1}, 32'd0);
    // start together with abort in IDLE is ignored
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", {31'd0, busy_1}, 32'd0);
    chk("start_abort_keep", {24'd0, err_1}, 32'd2);
    tie0_mode = 1'b0;
    pulse_start();
    chk("restart_clear", {23'd0, busy_1, err_1}, 32'h100);
    chk("restart_fv",    {31'd0, fv_1}, 32'd0);
    wait_done1(60);
    chk("restart_pass",  {31'd0, pass_1}, 32'd1);
    chk("restart_err",   {24'd0, err_1}, 32'd0);

    // ---------------- RN pulse during HOLD ----------------
    tie0_mode = 1'b1;
    pulse_start();
    for (int t = 1; t <= 4; t++) tick();
    chk("pre_rst_err", {24'd0, err_1}, 32'd1);
    RN = 1'b0;
    #2;
    chk("async_rst_busy", {31'd0, busy_1}, 32'd0);
    chk("async_rst_cut",  {28'd0, a1_1, a2_1, b_1, c_1}, 32'd0);
    chk("async_rst_err",  {24'd0, err_1}, 32'd0);
    chk("async_rst_fv",   {31'd0, fv_1}, 32'd0);
    tick();
    RN = 1'b1;
    tie0_mode = 1'b0;
    tick();
    pulse_start();
    for (int t = 1; t <= 9; t++) tick();
    start = 1'b1;                 // ignored while busy
    tick();
    start = 1'b0;
    for (int t = 11; t <= 13; t++) tick();
    chk("busy_start_ignored", {28'd0, a1_1, a2_1, b_1, c_1}, 32'd4);
    wait_done1(60);
    chk("clean_pass", {31'd0, pass_1}, 32'd1);
    chk("clean_err",  {24'd0, err_1}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
